// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with valid/ready handshake, flush and synchronous reset.
// Optional skid entry (second slot, registered in_ready) enabled by defining IF_ID_SKID_EN.
module if_id_pipe #(
    parameter int                   INSTR_W  = 8,
    parameter int                   PC_W     = 8,
    parameter logic [INSTR_W-1:0]   NOP_CODE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [1:0]         occupancy
);

`ifdef IF_ID_SKID_EN
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1, S_SKID = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1} state_t;
`endif

    state_t               r_state;
    logic                 r_out_valid;
    logic [1:0]           r_occupancy;
    logic [INSTR_W-1:0]   r_head_instr;
    logic [PC_W-1:0]      r_head_pc;

    state_t               w_nxt_state;
    logic [INSTR_W-1:0]   w_nxt_head_instr;
    logic [PC_W-1:0]      w_nxt_head_pc;
    logic                 w_accept;
    logic                 w_consume;

`ifdef IF_ID_SKID_EN
    logic [INSTR_W-1:0]   r_skid_instr;
    logic [PC_W-1:0]      r_skid_pc;
    logic [INSTR_W-1:0]   w_nxt_skid_instr;
    logic [PC_W-1:0]      w_nxt_skid_pc;

    // Ready depends only on registered state, breaking the out_ready -> in_ready path.
    assign in_ready = !rst && (r_state != S_SKID);
`else
    assign in_ready = !rst && (!r_out_valid || out_ready);
`endif

    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_out_valid && out_ready;

    assign out_valid = r_out_valid;
    assign out_instr = r_head_instr;
    assign out_pc    = r_head_pc;
    assign occupancy = r_occupancy;

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_head_instr = r_head_instr;
        w_nxt_head_pc    = r_head_pc;
`ifdef IF_ID_SKID_EN
        w_nxt_skid_instr = r_skid_instr;
        w_nxt_skid_pc    = r_skid_pc;
`endif
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_nxt_state      = S_FULL;
                    w_nxt_head_instr = in_instr;
                    w_nxt_head_pc    = in_pc;
                end
            end
            S_FULL: begin
                if (w_accept && w_consume) begin
                    w_nxt_head_instr = in_instr;
                    w_nxt_head_pc    = in_pc;
                end else if (w_consume) begin
                    // Head register parks at NOP so outputs need no gating.
                    w_nxt_state      = S_EMPTY;
                    w_nxt_head_instr = NOP_CODE;
                    w_nxt_head_pc    = '0;
                end
`ifdef IF_ID_SKID_EN
                else if (w_accept) begin
                    w_nxt_state      = S_SKID;
                    w_nxt_skid_instr = in_instr;
                    w_nxt_skid_pc    = in_pc;
                end
`endif
            end
`ifdef IF_ID_SKID_EN
            S_SKID: begin
                if (w_consume) begin
                    w_nxt_state      = S_FULL;
                    w_nxt_head_instr = r_skid_instr;
                    w_nxt_head_pc    = r_skid_pc;
                    w_nxt_skid_instr = '0;
                    w_nxt_skid_pc    = '0;
                end
            end
`endif
            default: begin
                w_nxt_state      = S_EMPTY;
                w_nxt_head_instr = NOP_CODE;
                w_nxt_head_pc    = '0;
            end
        endcase

        if (flush) begin
            w_nxt_state      = S_EMPTY;
            w_nxt_head_instr = NOP_CODE;
            w_nxt_head_pc    = '0;
`ifdef IF_ID_SKID_EN
            w_nxt_skid_instr = '0;
            w_nxt_skid_pc    = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_EMPTY;
            r_out_valid  <= 1'b0;
            r_occupancy  <= 2'd0;
            r_head_instr <= NOP_CODE;
            r_head_pc    <= '0;
`ifdef IF_ID_SKID_EN
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
`endif
        end else begin
            r_state      <= w_nxt_state;
            r_out_valid  <= (w_nxt_state != S_EMPTY);
            r_head_instr <= w_nxt_head_instr;
            r_head_pc    <= w_nxt_head_pc;
            case (w_nxt_state)
                S_FULL:  r_occupancy <= 2'd1;
`ifdef IF_ID_SKID_EN
                S_SKID:  r_occupancy <= 2'd2;
`endif
                default: r_occupancy <= 2'd0;
            endcase
`ifdef IF_ID_SKID_EN
            r_skid_instr <= w_nxt_skid_instr;
            r_skid_pc    <= w_nxt_skid_pc;
`endif
        end
    end

endmodule

// File: tb/tb_if_id_pipe.sv
// Self-checking bench for if_id_pipe: directed scenarios plus random traffic against a queue model.
// Honours IF_ID_SKID_EN the same way as the design (model capacity 2 vs 1).
module tb_if_id_pipe;
    localparam int             IW  = 8;
    localparam int             PW  = 8;
    localparam logic [IW-1:0]  NOP = 8'hEE;
`ifdef IF_ID_SKID_EN
    localparam int             CAP = 2;
`else
    localparam int             CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [IW-1:0] in_instr, out_instr;
    logic [PW-1:0] in_pc, out_pc;
    logic [1:0]    occupancy;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    logic [IW+PW-1:0] q[$];

    if_id_pipe #(.INSTR_W(IW), .PC_W(PW), .NOP_CODE(NOP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, exp finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check against the model, then advance the model at posedge.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [IW-1:0] ins, input logic [PW-1:0] pc, input logic ordy);
        logic             e_rdy, acc, con;
        logic [IW+PW-1:0] h;
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
        #1;
        if (r)             e_rdy = 1'b0;
        else if (CAP == 2) e_rdy = (q.size() < 2);
        else               e_rdy = (q.size() == 0) || ordy;
        h = (q.size() > 0) ? q[0] : {NOP, {PW{1'b0}}};
        if (chk_en) begin
            chk("in_ready",  32'(in_ready),  32'(e_rdy));
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("out_instr", 32'(out_instr), 32'(h[IW+PW-1:PW]));
            chk("out_pc",    32'(out_pc),    32'(h[PW-1:0]));
            chk("occupancy", 32'(occupancy), 32'(q.size()));
        end
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            acc = iv && e_rdy;
            con = (q.size() > 0) && ordy;
            if (con) void'(q.pop_front());
            if (f)        q.delete();
            else if (acc) q.push_back({ins, pc});
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, ordy);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        step(1'b1, 1'b0, 1'b1, 8'h99, 8'h99, 1'b0);
        chk_en = 1'b1;
        // Reset state and in_ready low during reset
        step(1'b1, 1'b0, 1'b1, 8'h98, 8'h01, 1'b1);
        // Single entry, one-cycle latency
        step(1'b0, 1'b0, 1'b1, 8'h11, 8'h04, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        if (chk_en) chk("req035_seen", 32'(q.size()), 32'd0);
        // Back-to-back stream
        step(1'b0, 1'b0, 1'b1, 8'h21, 8'h10, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h22, 8'h11, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h23, 8'h12, 1'b1);
        idle(2, 1'b1);
        // Stall with two offers, then drain
        step(1'b0, 1'b0, 1'b1, 8'h31, 8'h20, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h32, 8'h21, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h32, 8'h21, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h32, 8'h21, 1'b1);
        idle(3, 1'b1);
        // Fill, then flush with an offered entry that must be dropped
        step(1'b0, 1'b0, 1'b1, 8'h35, 8'h30, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h36, 8'h31, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h41, 8'h32, 1'b0);
        idle(2, 1'b1);
        // Reset mid-stream with in_valid high, then resume
        step(1'b0, 1'b0, 1'b1, 8'h51, 8'h40, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h52, 8'h41, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h53, 8'h42, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h54, 8'h43, 1'b1);
        idle(2, 1'b1);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 6 : 3)));
        end
        idle(3, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter INSTR_W, default 8, instruction code width in bits.
REQ-002 Parameter PC_W, default 8, program-counter width in bits.
REQ-003 Parameter NOP_CODE, default 0 (INSTR_W bits), code driven on out_instr whenever out_valid is low.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 flush  input  1  discards all held entries and any entry accepted in the same cycle.
REQ-007 in_valid  input  1  fetch stage offers an entry.
REQ-008 in_ready  output  1  block can accept an entry this cycle.
REQ-009 in_instr  input  INSTR_W  fetched instruction code.
REQ-010 in_pc  input  PC_W  PC of the fetched instruction.
REQ-011 out_valid  output  1  decode-side entry is present.
REQ-012 out_ready  input  1  decode stage consumes the entry this cycle.
REQ-013 out_instr  output  INSTR_W  head instruction, or NOP_CODE when out_valid is low.
REQ-014 out_pc  output  PC_W  head PC, or 0 when out_valid is low.
REQ-015 occupancy  output  2  entries currently held: 0..1, or 0..2 with skid.

Function
REQ-016 An accept SHALL occur when in_valid && in_ready at a clock edge; a consume SHALL occur when out_valid && out_ready.
REQ-017 An entry accepted into an empty block SHALL appear on out_valid/out_instr/out_pc exactly one cycle later.
REQ-018 Entries SHALL leave in acceptance order, each exactly once, with instr and pc kept paired.
REQ-019 Outputs out_valid, out_instr, out_pc and occupancy SHALL be driven directly from registers, with no combinational path from in_* to out_*.
REQ-020 The control state machine SHALL have states EMPTY and FULL, plus SKID when the skid feature is compiled in.
REQ-021 EMPTY→FULL SHALL occur on accept; FULL→EMPTY on consume without accept; FULL→FULL on consume with accept (head replaced).
REQ-022 With skid, FULL→SKID SHALL occur on accept without consume (new entry parked in skid register).
REQ-023 With skid, SKID→FULL SHALL occur on consume, with the skid entry moving to head in the same edge.
REQ-024 Simultaneous accept with consume in SKID is impossible, because in_ready is low in SKID.
REQ-025 Flush SHALL force state EMPTY at the next edge, regardless of in_valid/out_ready.
REQ-026 An entry presented on the flush cycle SHALL be dropped, even if in_ready was high.
REQ-027 A consume on the flush cycle still completes from the decode side's view; the head is not re-presented.
REQ-028 in_valid with in_ready low SHALL leave state and data unchanged; the source must hold its entry.
REQ-029 A stalled head (out_valid && !out_ready) SHALL hold out_instr/out_pc stable.

Reset
REQ-030 While rst is high at an edge, state SHALL become EMPTY, occupancy=0, out_valid=0, out_instr=NOP_CODE, out_pc=0, skid register=0.
REQ-031 rst SHALL take priority over flush, accept and consume; an entry offered during reset is dropped.
REQ-032 in_ready SHALL be 0 while rst is high, and from the first edge after reset deasserts it takes its normal value.

Configuration
REQ-033 Macro IF_ID_SKID_EN defined: skid register present; in_ready = (state != SKID), a registered-state-only function independent of out_ready; occupancy ranges 0..2.
REQ-034 Macro IF_ID_SKID_EN undefined: no skid register; in_ready = !out_valid || out_ready (combinational pass-through of out_ready); occupancy ranges 0..1.

Verification
REQ-035 Reset, then offer instr=0x11 with pc=0x04 one cycle, out_ready=1 -> next cycle out_valid=1, out_instr=0x11, out_pc=0x04, occupancy=1.
REQ-036 Stream 0x21,0x22,0x23 on consecutive cycles, out_ready=1 throughout -> same three codes out on consecutive cycles, one-cycle latency, no bubbles.
REQ-037 (skid) Hold out_ready=0, offer 0x31 then 0x32 -> occupancy=2, in_ready=0; raise out_ready -> 0x31 then 0x32 delivered in order.
REQ-038 Occupancy=2, then assert flush one cycle with in_valid=1, instr=0x41 -> next cycle out_valid=0, out_instr=NOP_CODE, occupancy=0, 0x41 never emitted.
REQ-039 Mid-stream assert rst with in_valid=1 -> next cycle all outputs at reset values, in_ready=0 during reset, normal acceptance resumes after rst deasserts.
